// File: rtl/ga_eval_scheduler.sv
// Generation-level controller for the GA fitness/best-tracking datapath: walks the
// population two entries per cycle, checks convergence, and hands off to the evolve engine.
module ga_eval_scheduler #(
    parameter int unsigned FITNESS_WIDTH = 27,
    parameter int unsigned CHROM_WIDTH   = 8,
    parameter int unsigned POP_SIZE      = 16,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned FIT_LATENCY   = 3,
    parameter int unsigned GEN_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [GEN_WIDTH-1:0]     max_gen,
    input  logic [FITNESS_WIDTH-1:0] target_fit,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr1,
    output logic [ADDR_WIDTH-1:0]    rd_addr2,
    output logic                     best_reset,
    output logic                     best_enable,
    output logic                     best_enable_second,
    input  logic [FITNESS_WIDTH-1:0] best_fit,
    input  logic [CHROM_WIDTH-1:0]   best_chrom,
    output logic                     evo_start,
    input  logic                     evo_done,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic [GEN_WIDTH-1:0]     gen_count,
    output logic [FITNESS_WIDTH-1:0] result_fit,
    output logic [CHROM_WIDTH-1:0]   result_chrom
);

    localparam int unsigned NUM_PAIRS  = (POP_SIZE + 1) / 2;
    localparam int unsigned PIPE_DEPTH = FIT_LATENCY + 1;
    localparam int unsigned DRAIN_W    = $clog2(FIT_LATENCY + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(NUM_PAIRS - 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_END = DRAIN_W'(FIT_LATENCY);
    localparam bit POP_ODD = (POP_SIZE % 2) == 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_CHECK  = 3'd4,
        S_EVOLVE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pair_q, pair_d;
    logic [DRAIN_W-1:0]       drain_q, drain_d;
    logic [GEN_WIDTH-1:0]     gen_q, gen_d;
    logic [GEN_WIDTH-1:0]     max_gen_q, max_gen_d;
    logic [FITNESS_WIDTH-1:0] target_q, target_d;
    logic                     conv_q, conv_d;
    logic [FITNESS_WIDTH-1:0] res_fit_q, res_fit_d;
    logic [CHROM_WIDTH-1:0]   res_chrom_q, res_chrom_d;

    logic                     rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]    addr1_q, addr1_d;
    logic [ADDR_WIDTH-1:0]    addr2_q, addr2_d;
    logic                     second_q, second_d;
    logic                     best_reset_q, best_reset_d;
    logic                     evo_start_q, evo_start_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Valid/second-lane delay line; its tail is the tracker update qualifier.
    logic [PIPE_DEPTH-1:0]    pipe_v_q;
    logic [PIPE_DEPTH-1:0]    pipe_s_q;

    logic [GEN_WIDTH-1:0]     gen_inc;

    assign gen_inc = (&gen_q) ? gen_q : gen_q + GEN_WIDTH'(1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pair_q       <= '0;
            drain_q      <= '0;
            gen_q        <= '0;
            max_gen_q    <= '0;
            target_q     <= '0;
            conv_q       <= 1'b0;
            res_fit_q    <= '0;
            res_chrom_q  <= '0;
            rd_en_q      <= 1'b0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            second_q     <= 1'b0;
            best_reset_q <= 1'b0;
            evo_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pipe_v_q     <= '0;
            pipe_s_q     <= '0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            drain_q      <= drain_d;
            gen_q        <= gen_d;
            max_gen_q    <= max_gen_d;
            target_q     <= target_d;
            conv_q       <= conv_d;
            res_fit_q    <= res_fit_d;
            res_chrom_q  <= res_chrom_d;
            rd_en_q      <= rd_en_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            second_q     <= second_d;
            best_reset_q <= best_reset_d;
            evo_start_q  <= evo_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pipe_v_q     <= (pipe_v_q << 1) | PIPE_DEPTH'(rd_en_q);
            pipe_s_q     <= (pipe_s_q << 1) | PIPE_DEPTH'(second_q);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        drain_d     = drain_q;
        gen_d       = gen_q;
        max_gen_d   = max_gen_q;
        target_d    = target_q;
        conv_d      = conv_q;
        res_fit_d   = res_fit_q;
        res_chrom_d = res_chrom_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    max_gen_d = (max_gen == '0) ? GEN_WIDTH'(1) : max_gen;
                    target_d  = target_fit;
                    gen_d     = '0;
                    conv_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                pair_d  = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (pair_q == LAST_PAIR) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    pair_d = pair_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // Hold until the last pair has left the pipeline and the tracker has settled.
                if (drain_q == DRAIN_END) begin
                    state_d = S_CHECK;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_CHECK: begin
                gen_d = gen_inc;
                if (best_fit <= target_q) begin
                    conv_d      = 1'b1;
                    res_fit_d   = best_fit;
                    res_chrom_d = best_chrom;
                    state_d     = S_DONE;
                end else if (gen_inc == max_gen_q) begin
                    res_fit_d   = best_fit;
                    res_chrom_d = best_chrom;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_EVOLVE;
                end
            end
            S_EVOLVE: begin
                if (evo_done) begin
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        rd_en_d      = 1'b0;
        addr1_d      = '0;
        addr2_d      = '0;
        second_d     = 1'b0;
        best_reset_d = 1'b0;
        evo_start_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        unique case (state_d)
            S_CLEAR: begin
                best_reset_d = 1'b1;
                busy_d       = 1'b1;
            end
            S_ISSUE: begin
                rd_en_d  = 1'b1;
                busy_d   = 1'b1;
                addr1_d  = ADDR_WIDTH'({pair_d, 1'b0});
                second_d = !(POP_ODD && (pair_d == LAST_PAIR));
                addr2_d  = second_d ? (addr1_d | ADDR_WIDTH'(1)) : addr1_d;
            end
            S_DRAIN, S_CHECK: begin
                busy_d = 1'b1;
            end
            S_EVOLVE: begin
                busy_d      = 1'b1;
                evo_start_d = (state_q != S_EVOLVE);
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign rd_en              = rd_en_q;
    assign rd_addr1           = addr1_q;
    assign rd_addr2           = addr2_q;
    assign best_reset         = best_reset_q;
    assign best_enable        = pipe_v_q[PIPE_DEPTH-1];
    assign best_enable_second = pipe_v_q[PIPE_DEPTH-1] & pipe_s_q[PIPE_DEPTH-1];
    assign evo_start          = evo_start_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign converged          = conv_q;
    assign gen_count          = gen_q;
    assign result_fit         = res_fit_q;
    assign result_chrom       = res_chrom_q;

endmodule
